z_seq_ctrl: RTL and testbench
=============================

Name: z_seq_ctrl

Overview:
- Moore-style sequencer that drives the Y/ALU/Z/HI/LO control strobes for one register-to-register ALU instruction on the shared 32-bit bus.
- Supports single-cycle ALU ops and multi-cycle MUL/DIV, for which it waits on an iterative unit's done flag.
- It sits between the instruction decoder and the datapath.
- It owns all Zin/Zlowout/Zhighout sequencing, so Z never drives the bus with both halves at once.

Parameters:
- TIMEOUT, 40, maximum number of cycles in WAIT before the operation is aborted with an error.
- CNT_W, 6, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and zeroes every registered output
- start  in  1  one-cycle request from the decoder; sampled only in IDLE
- op  in  2  00 = single-cycle ALU op, 01 = MUL, 10 = DIV, 11 = reserved
- alu_done  in  1  iterative MUL/DIV unit finished; result is valid on the ALU bus this cycle
- div_zero  in  1  qualifies alu_done for DIV only
- Gra, Grb, Rout  out  1  register-select strobes for operand A and operand B
- Yin  out  1  load Y from the bus
- alu_start  out  1  one-cycle start pulse to the ALU/iterative unit
- Zin  out  1  latch the 64-bit ALU result into Z
- Zlowout, Zhighout  out  1  Z bus drivers; never asserted together
- LOin, HIin, Rin  out  1  writeback enables
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes successfully
- err  out  1  one-cycle pulse on reserved op, divide-by-zero or timeout

Behaviour:
- General rules
  - All outputs are decoded from registered state; every output is 0 in reset and in IDLE.
  - op is captured into op_q when start is accepted; later changes to op are ignored.
- States and strobes
  - IDLE: if start && op==11 → ERR. If start otherwise → RA. Else stay in IDLE.
  - RA: Gra=Rout=Yin=1 → RB.
  - RB: Grb=Rout=alu_start=1.
    - op_q==00 → LATCH.
    - Otherwise → WAIT, with the counter cleared.
  - WAIT: counter increments each cycle.
    - alu_done && op_q==10 && div_zero → ERR.
    - alu_done (any other case) → LATCH.
    - counter==TIMEOUT-1 without alu_done → ERR.
    - alu_done takes priority over timeout in the same cycle.
  - LATCH: Zin=1.
    - op_q==00 → WLO_R.
    - Otherwise → WLO.
  - WLO_R: Zlowout=Rin=1 → DONE.
  - WLO: Zlowout=LOin=1 → WHI.
  - WHI: Zhighout=HIin=1 → DONE.
  - DONE: done=1 → IDLE.
  - ERR: err=1, Zin is never asserted on this path → IDLE.
- Latency (accepting edge = cycle 0)
  - Single-cycle op: done is high in cycle 5.
  - MUL/DIV with alu_done first seen in WAIT cycle n (n=0 is the first WAIT cycle): done is high in cycle n+7.
- Boundary conditions
  - start while busy is ignored; there is no queueing.
  - alu_done outside WAIT is ignored.
  - reset mid-operation returns to IDLE on the next evaluation. All strobes drop to 0 asynchronously and the counter clears. Z/HI/LO contents are not this block's concern.
  - Invariants: at most one of Zlowout/Zhighout is high; at most one of Gra/Grb is high; done and err are never high together.

Decomposition:
- Shared CPU package holds:
  - op encodings OP_ALU=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSVD=2'b11
  - the state enum IDLE, RA, RB, WAIT, LATCH, WLO_R, WLO, WHI, DONE, ERR
- Single module, no sub-module. The timeout counter is small enough to stay inline.

Test Plan:
- Reset asserted mid-WAIT (MUL, 3 cycles in) → all outputs 0 immediately. After release and no start, stays IDLE with busy=0.
- start, op=00 at cycle 0 → the following pulses, with done=1 at cycle 5 and LOin/HIin never asserted:
  - cycle 1: Gra/Rout/Yin
  - cycle 2: Grb/Rout/alu_start
  - cycle 3: Zin
  - cycle 4: Zlowout+Rin
- start, op=01; alu_done in WAIT cycle 10 → the following pulses, with done=1 at cycle 17:
  - cycle 14: Zin
  - cycle 15: Zlowout+LOin
  - cycle 16: Zhighout+HIin
- start, op=10; alu_done=1 with div_zero=1 in WAIT cycle 2 → err=1 at cycle 6, then IDLE. Zin, LOin, HIin and done are never asserted.
- start, op=01 with alu_done held low, TIMEOUT=40 → err=1 exactly 40 WAIT cycles after entering WAIT, then IDLE. A second run with alu_done arriving in the final WAIT cycle → LATCH, not err.
- start, op=11 → err=1 next cycle, no strobes. start pulsed again during RA of an op=00 sequence → ignored, exactly one done.

Source files
------------

// File: rtl/z_seq_ctrl_pkg.sv
// Shared CPU definitions for the ALU instruction sequencer: op encodings and
// the sequencer state enum.
package z_seq_ctrl_pkg;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    RA,
    RB,
    WAIT,
    LATCH,
    WLO_R,
    WLO,
    WHI,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/z_seq_ctrl.sv
// Moore sequencer issuing the Y/ALU/Z/HI/LO strobes for one register-to-register
// ALU instruction; MUL/DIV wait on the iterative unit with a timeout.
module z_seq_ctrl
  import z_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       alu_done,
  input  logic       div_zero,
  output logic       Gra,
  output logic       Grb,
  output logic       Rout,
  output logic       Yin,
  output logic       alu_start,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Zhighout,
  output logic       LOin,
  output logic       HIin,
  output logic       Rin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // op is latched only on acceptance; the counter runs only while in WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= OP_ALU;
      cnt  <= '0;
    end else begin
      if (state == IDLE && start) op_q <= op;
      if (state == RB)            cnt  <= '0;
      else if (state == WAIT)     cnt  <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && op == OP_RSVD) state_nx = ERR;
        else if (start)             state_nx = RA;
      end
      RA:    state_nx = RB;
      RB:    state_nx = (op_q == OP_ALU) ? LATCH : WAIT;
      WAIT: begin
        // a completion in the last allowed cycle beats the timeout
        if (alu_done && op_q == OP_DIV && div_zero) state_nx = ERR;
        else if (alu_done)                          state_nx = LATCH;
        else if (cnt == CNT_W'(TIMEOUT - 1))        state_nx = ERR;
      end
      LATCH: state_nx = (op_q == OP_ALU) ? WLO_R : WLO;
      WLO_R: state_nx = DONE;
      WLO:   state_nx = WHI;
      WHI:   state_nx = DONE;
      DONE:  state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Gra       = 1'b0;
    Grb       = 1'b0;
    Rout      = 1'b0;
    Yin       = 1'b0;
    alu_start = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    Rin       = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    case (state)
      RA: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
      end
      RB: begin
        Grb       = 1'b1;
        Rout      = 1'b1;
        alu_start = 1'b1;
      end
      LATCH: Zin = 1'b1;
      WLO_R: begin
        Zlowout = 1'b1;
        Rin     = 1'b1;
      end
      WLO: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      WHI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_z_seq_ctrl.sv
// Directed bench for z_seq_ctrl: every cycle's full strobe vector is compared
// against a hand-derived pattern.
module tb_z_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic       alu_done;
  logic       div_zero;
  logic       Gra, Grb, Rout, Yin, alu_start, Zin, Zlowout, Zhighout;
  logic       LOin, HIin, Rin, busy, done, err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  z_seq_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .alu_done(alu_done), .div_zero(div_zero),
    .Gra(Gra), .Grb(Grb), .Rout(Rout), .Yin(Yin), .alu_start(alu_start),
    .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .Rin(Rin),
    .busy(busy), .done(done), .err(err)
  );

  // {Gra Grb Rout Yin | alu_start Zin Zlowout Zhighout | LOin HIin Rin busy | done err}
  logic [13:0] outs;
  assign outs = {Gra, Grb, Rout, Yin, alu_start, Zin, Zlowout, Zhighout,
                 LOin, HIin, Rin, busy, done, err};

  localparam logic [13:0] P_IDLE  = 14'b0000_0000_0000_00;
  localparam logic [13:0] P_RA    = 14'b1011_0000_0001_00;
  localparam logic [13:0] P_RB    = 14'b0110_1000_0001_00;
  localparam logic [13:0] P_WAIT  = 14'b0000_0000_0001_00;
  localparam logic [13:0] P_LATCH = 14'b0000_0100_0001_00;
  localparam logic [13:0] P_WLOR  = 14'b0000_0010_0011_00;
  localparam logic [13:0] P_WLO   = 14'b0000_0010_1001_00;
  localparam logic [13:0] P_WHI   = 14'b0000_0001_0101_00;
  localparam logic [13:0] P_DONE  = 14'b0000_0000_0001_10;
  localparam logic [13:0] P_ERR   = 14'b0000_0000_0001_01;

  task automatic chk(input string tag, input logic [13:0] exp);
    total++;
    assert (outs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    alu_done = 1'b0;
    div_zero = 1'b0;
    tick();
    tick();
    chk("reset_state", P_IDLE);
    reset = 1'b0;
    tick();

    // MUL, reset asserted three cycles into WAIT
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    chk("rst_mul_ra", P_RA);
    tick();
    tick();
    tick();
    tick();
    chk("rst_mul_wait", P_WAIT);
    #2 reset = 1'b1;
    #1 chk("rst_async_drop", P_IDLE);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_idle_after", P_IDLE);

    // single-cycle ALU op; op changes after acceptance are ignored
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0; op = 2'b01;
    chk("alu_c1", P_RA);
    tick(); chk("alu_c2", P_RB);
    tick(); chk("alu_c3", P_LATCH);
    tick(); chk("alu_c4", P_WLOR);
    tick(); chk("alu_c5", P_DONE);
    tick(); chk("alu_c6", P_IDLE);

    // MUL, done seen in WAIT cycle 10; stray alu_done in RA and div_zero on MUL ignored
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; alu_done = 1'b1;
    chk("mul_c1", P_RA);
    tick();
    alu_done = 1'b0;
    chk("mul_c2", P_RB);
    tick();
    for (int n = 0; n < 10; n++) begin
      chk("mul_wait", P_WAIT);
      tick();
    end
    alu_done = 1'b1; div_zero = 1'b1;
    chk("mul_c13", P_WAIT);
    tick();
    alu_done = 1'b0; div_zero = 1'b0;
    chk("mul_c14", P_LATCH);
    tick(); chk("mul_c15", P_WLO);
    tick(); chk("mul_c16", P_WHI);
    tick(); chk("mul_c17", P_DONE);
    tick(); chk("mul_c18", P_IDLE);

    // DIV by zero reported in WAIT cycle 2
    start = 1'b1; op = 2'b10;
    tick();
    start = 1'b0;
    chk("div_c1", P_RA);
    tick(); chk("div_c2", P_RB);
    tick(); chk("div_c3", P_WAIT);
    tick(); chk("div_c4", P_WAIT);
    tick();
    alu_done = 1'b1; div_zero = 1'b1;
    chk("div_c5", P_WAIT);
    tick();
    alu_done = 1'b0; div_zero = 1'b0;
    chk("div_c6_err", P_ERR);
    tick(); chk("div_c7", P_IDLE);

    // MUL timeout: 40 WAIT cycles then err
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int n = 0; n < 40; n++) begin
      chk("to_wait", P_WAIT);
      tick();
    end
    chk("to_err", P_ERR);
    tick(); chk("to_idle", P_IDLE);

    // alu_done in the final WAIT cycle wins over timeout
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int n = 0; n < 39; n++) begin
      chk("late_wait", P_WAIT);
      tick();
    end
    alu_done = 1'b1;
    chk("late_c42", P_WAIT);
    tick();
    alu_done = 1'b0;
    chk("late_latch", P_LATCH);
    tick(); chk("late_wlo", P_WLO);
    tick(); chk("late_whi", P_WHI);
    tick(); chk("late_done", P_DONE);
    tick(); chk("late_idle", P_IDLE);

    // reserved op
    start = 1'b1; op = 2'b11;
    tick();
    start = 1'b0;
    chk("rsvd_err", P_ERR);
    tick(); chk("rsvd_idle", P_IDLE);

    // start again during RA is ignored: exactly one done, no restart
    start = 1'b1; op = 2'b00;
    tick();
    op = 2'b01;
    chk("busy_ra", P_RA);
    tick();
    start = 1'b0;
    chk("busy_rb", P_RB);
    tick(); chk("busy_latch", P_LATCH);
    tick(); chk("busy_wlor", P_WLOR);
    tick(); chk("busy_done", P_DONE);
    tick(); chk("busy_idle1", P_IDLE);
    tick(); chk("busy_idle2", P_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
